// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line in, received word plus status out.
// master = receiver core, slave = pad/consumer side.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_data_out;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;
    logic                 rx_busy;

    modport master (
        input  rx_serial,
        output rx_data_out,
        output rx_valid,
        output rx_parity_err,
        output rx_frame_err,
        output rx_break,
        output rx_busy
    );

    modport slave (
        output rx_serial,
        input  rx_data_out,
        input  rx_valid,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_break,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (5..9 data bits, none/even/odd parity, 1-2 stop bits).
// Latency ~2+HALF+bits*CLKS_PER_BIT+1 cycles; no backpressure, rx_valid is a 1-cycle pulse.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            rx_clk,
    input  logic            rx_rst_n,
    uart_rx_param_if.master rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF      = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);
    localparam logic          HAS_PAR   = (PARITY_MODE != 0);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] CLEANUP = 3'd5;

    logic                 s1;
    logic                 s2;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 par_err;
    logic                 frm_err;
    logic                 pending;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 brk_q;

    logic                 cnt_done;

    assign cnt_done = (cnt == LAST_CNT);

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            pending  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            s1      <= rx.rx_serial;
            s2      <= s1;
            valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    cnt      <= '0;
                    idx      <= '0;
                    stop_idx <= 1'b0;
                    if (!s2) begin
                        state   <= START;
                        par_bit <= 1'b0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                end

                // Re-check the line mid start bit; a high here is a glitch.
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= s2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_done) begin
                        cnt        <= '0;
                        shift[idx] <= s2;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= HAS_PAR ? PARITY : STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt_done) begin
                        cnt     <= '0;
                        par_bit <= s2;
                        par_err <= ((^shift) ^ s2) != ODD_PAR;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        if (!s2) begin
                            frm_err <= 1'b1;
                        end
                        if (stop_idx == STOP_LAST) begin
                            stop_idx <= 1'b0;
                            pending  <= 1'b1;
                            state    <= CLEANUP;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Deliver on the first cycle here, then hold while the line is
                // still low so a break cannot retrigger a new frame.
                CLEANUP: begin
                    if (pending) begin
                        pending <= 1'b0;
                        valid_q <= 1'b1;
                        data_q  <= shift;
                        perr_q  <= par_err;
                        ferr_q  <= frm_err;
                        brk_q   <= frm_err && (shift == '0) && !par_bit;
                    end
                    if (s2) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    idx      <= '0;
                    stop_idx <= 1'b0;
                    pending  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_data_out   = data_q;
    assign rx.rx_valid      = valid_q;
    assign rx.rx_parity_err = perr_q;
    assign rx.rx_frame_err  = ferr_q;
    assign rx.rx_break      = brk_q;
    assign rx.rx_busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) at 16 clocks/bit.
module tb_uart_rx_param;
    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) ia ();
    uart_rx_param_if #(.DATA_BITS(8)) ib ();
    uart_rx_param_if #(.DATA_BITS(7)) ic ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx(ia.master));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_b (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx(ib.master));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx(ic.master));

    int         cnt_a = 0;
    int         cnt_b = 0;
    int         cnt_c = 0;
    logic [6:0] qc_dat[$];
    logic       qc_fe[$];

    always @(negedge clk) begin
        if (ia.rx_valid === 1'b1) cnt_a++;
        if (ib.rx_valid === 1'b1) cnt_b++;
        if (ic.rx_valid === 1'b1) begin
            cnt_c++;
            qc_dat.push_back(ic.rx_data_out);
            qc_fe.push_back(ic.rx_frame_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int dut, input logic v);
        case (dut)
            0:       ia.rx_serial = v;
            1:       ib.rx_serial = v;
            default: ic.rx_serial = v;
        endcase
    endtask

    // Bits go out LSB first, one bit per CPB clocks; caller sits just after a posedge.
    task automatic send_bits(input int dut, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(dut, bits[i]);
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        ia.rx_serial = 1'b1;
        ib.rx_serial = 1'b1;
        ic.rx_serial = 1'b1;
        rst_n        = 1'b0;
        idle(3);
        chk("rst_data",  ia.rx_data_out, 32'h0);
        chk("rst_valid", ia.rx_valid, 32'h0);
        chk("rst_flags", {ia.rx_parity_err, ia.rx_frame_err, ia.rx_break}, 32'h0);
        chk("rst_busy",  ia.rx_busy, 32'h0);
        rst_n = 1'b1;
        idle(4);

        // 8N1 0xA5
        send_bits(0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10);
        idle(CPB);
        chk("a5_count", cnt_a, 32'd1);
        chk("a5_data",  ia.rx_data_out, 32'hA5);
        chk("a5_flags", {ia.rx_parity_err, ia.rx_frame_err, ia.rx_break}, 32'h0);
        chk("a5_busy",  ia.rx_busy, 32'h0);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
        send_bits(1, {5'h0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        idle(CPB);
        chk("par1_count", cnt_b, 32'd1);
        chk("par1_data",  ib.rx_data_out, 32'h03);
        chk("par1_perr",  ib.rx_parity_err, 32'h1);
        chk("par1_ferr",  ib.rx_frame_err, 32'h0);
        send_bits(1, {5'h0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        idle(CPB);
        chk("par0_count", cnt_b, 32'd2);
        chk("par0_data",  ib.rx_data_out, 32'h03);
        chk("par0_perr",  ib.rx_parity_err, 32'h0);

        // 5-cycle glitch, shorter than HALF=7
        set_line(0, 1'b0);
        idle(4);
        chk("glitch_busy", ia.rx_busy, 32'h1);
        idle(1);
        set_line(0, 1'b1);
        idle(3 * CPB);
        chk("glitch_count", cnt_a, 32'd1);
        chk("glitch_data",  ia.rx_data_out, 32'hA5);
        chk("glitch_idle",  ia.rx_busy, 32'h0);

        // Break: line low for three frame times
        set_line(0, 1'b0);
        idle(300);
        chk("brk_count", cnt_a, 32'd2);
        chk("brk_data",  ia.rx_data_out, 32'h0);
        chk("brk_flags", {ia.rx_parity_err, ia.rx_frame_err, ia.rx_break}, 32'h3);
        chk("brk_hold",  ia.rx_busy, 32'h1);
        idle(180);
        chk("brk_single", cnt_a, 32'd2);
        set_line(0, 1'b1);
        idle(3 * CPB);
        chk("brk_release", ia.rx_busy, 32'h0);
        chk("brk_nodup",   cnt_a, 32'd2);
        send_bits(0, {6'h0, 1'b1, 8'h5A, 1'b0}, 10);
        idle(CPB);
        chk("post_brk_count", cnt_a, 32'd3);
        chk("post_brk_data",  ia.rx_data_out, 32'h5A);
        chk("post_brk_flags", {ia.rx_parity_err, ia.rx_frame_err, ia.rx_break}, 32'h0);

        // 7N2: second stop bit low, then two frames back-to-back
        send_bits(2, {6'h0, 1'b0, 1'b1, 7'h55, 1'b0}, 10);
        set_line(2, 1'b1);
        idle(2 * CPB);
        chk("stop2_count", cnt_c, 32'd1);
        chk("stop2_data",  ic.rx_data_out, 32'h55);
        chk("stop2_ferr",  ic.rx_frame_err, 32'h1);
        chk("stop2_brk",   ic.rx_break, 32'h0);
        send_bits(2, {6'h0, 2'b11, 7'h2A, 1'b0}, 10);
        send_bits(2, {6'h0, 2'b11, 7'h7F, 1'b0}, 10);
        idle(CPB);
        chk("b2b_count", cnt_c, 32'd3);
        if (qc_dat.size() >= 3) begin
            chk("b2b_first_data",  qc_dat[1], 32'h2A);
            chk("b2b_first_ferr",  qc_fe[1], 32'h0);
            chk("b2b_second_data", qc_dat[2], 32'h7F);
            chk("b2b_second_ferr", qc_fe[2], 32'h0);
        end

        // Reset one cycle in the middle of data bit 4 of 0x3C
        send_bits(0, {6'h0, 1'b1, 8'h3C, 1'b0}, 5);
        set_line(0, 1'b1);
        idle(8);
        chk("mid_busy", ia.rx_busy, 32'h1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("mid_rst_data",  ia.rx_data_out, 32'h0);
        chk("mid_rst_valid", ia.rx_valid, 32'h0);
        chk("mid_rst_flags", {ia.rx_parity_err, ia.rx_frame_err, ia.rx_break}, 32'h0);
        chk("mid_rst_busy",  ia.rx_busy, 32'h0);
        chk("mid_rst_c_data", ic.rx_data_out, 32'h0);
        idle(6 * CPB);
        chk("mid_rst_novalid", cnt_a, 32'd3);
        send_bits(0, {6'h0, 1'b1, 8'h3C, 1'b0}, 10);
        idle(CPB);
        chk("after_rst_count", cnt_a, 32'd4);
        chk("after_rst_data",  ia.rx_data_out, 32'h3C);
        chk("after_rst_flags", {ia.rx_parity_err, ia.rx_frame_err, ia.rx_break}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the fixed 8N1 receiver. It supports a configurable data width, optional even/odd parity, and 1 or 2 stop bits. It adds a synchronous active-low reset, a one-cycle valid strobe, and parity, framing and break error flags. It sits between the rx_serial pad and the byte consumer (FIFO or register file) in the UART subsystem.

Parameters:
CLKS_PER_BIT, 87, rx_clk cycles per serial bit; legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
rx_clk  in  1  sole clock; all logic is on the posedge.
rx_rst_n  in  1  synchronous active-low reset.
rx_serial  in  1  asynchronous serial line; idles high.
rx_data_out  out  DATA_BITS  last received word, LSB received first.
rx_valid  out  1  one-cycle pulse when rx_data_out and the flags update.
rx_parity_err  out  1  parity mismatch on the last frame (0 when PARITY_MODE=0).
rx_frame_err  out  1  a stop bit sampled low on the last frame.
rx_break  out  1  last frame was all-zero, including parity and stop.
rx_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is sampled on posedge rx_clk while rx_rst_n=0.
  - State returns to IDLE; clock counter and bit index clear to 0.
  - Both synchroniser flops are set to 1.
  - All outputs go to 0.
  - A reset mid-frame abandons the frame; no rx_valid is produced.
- Input synchroniser: 2-flop chain, rx_serial -> s1 -> s2. All decisions use s2, so 2 cycles of input latency.
- Clock counter width is $clog2(CLKS_PER_BIT); no wrap occurs because it is cleared at every bit boundary.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP.
  - IDLE: counter=0, index=0. s2=0 -> START.
  - START: count up to HALF. At HALF, s2=0 -> counter=0, go DATA. At HALF, s2=1 -> false start, return to IDLE with no outputs changed.
  - DATA: at count CLKS_PER_BIT-1, shift s2 into shift[index] and clear counter. When index=DATA_BITS-1, go PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: sample at CLKS_PER_BIT-1. Error when XOR(data bits, parity bit) != 0 for even, or != 1 for odd.
  - STOP: sample each stop bit at CLKS_PER_BIT-1. Any stop bit low sets the frame error.
  - After the last stop sample, on the next edge:
    - rx_data_out <= shift; rx_valid=1 for exactly 1 cycle.
    - All three flags update in that same cycle and hold until the next rx_valid.
    - Then go to CLEANUP.
  - CLEANUP: if s2=1, go to IDLE on the next cycle. If s2=0, which happens after a framing error or break, stay until s2=1. This prevents retriggering mid-break.
- rx_break = frame_err AND all data bits = 0 AND (no parity OR parity bit = 0). A break always also asserts rx_frame_err.
- Parity or framing errors do not suppress rx_valid; data is delivered with its flags.
- Sampling point is mid-bit. Frame latency from the start-bit falling edge at the pin is about 2 + HALF + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if parity is enabled, else 0.
- Back-to-back frames: a start bit immediately following the stop bit must be accepted, since CLEANUP is 1 cycle when the line is high.
- Any illegal state encoding recovers to IDLE.

Test Plan:
- Defaults with CLKS_PER_BIT=16, 8N1, send 0xA5 -> exactly one rx_valid pulse, rx_data_out=0xA5, all flags 0, rx_busy low afterwards.
- PARITY_MODE=1, send 0x03 with parity bit 1 -> rx_data_out=0x03, rx_parity_err=1. Resend with parity bit 0 -> rx_parity_err=0.
- Line low for 5 cycles (< HALF=7), then high -> no rx_valid; state back in IDLE; rx_data_out unchanged.
- Hold line low for 3 frame times, then release -> single rx_valid, rx_data_out=0x00, rx_frame_err=1, rx_break=1. No second frame is decoded until after the line returns high.
- STOP_BITS=2, DATA_BITS=7: send 0x55 with second stop bit low -> rx_frame_err=1. Send 0x2A then 0x7F back-to-back -> two valid pulses in order, with no errors.
- Assert rx_rst_n=0 for 1 cycle during DATA bit 4 -> all outputs 0, no rx_valid. The next clean frame 0x3C is received correctly.
